peri_pdm_speaker: RTL

Wishbone B4 peripheral that drives a 1-bit PDM stream to a PDM amplifier or speaker. It is the transmit counterpart of the PDM microphone input. The CPU writes 8-bit unsigned PCM samples into a small FIFO. A first-order sigma-delta modulator turns each sample into Osr PDM bits, clocked out alongside a generated pdm_clk_o. An interrupt requests refill when the FIFO runs low.

---
 rtl/peri_pdm_pkg.sv | 37 +++
 rtl/peri_pdm_fifo.sv | 63 ++++++
 rtl/peri_pdm_speaker.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/peri_pdm_pkg.sv
// Shared constants and types for the PDM speaker peripheral.
// Optional dither LFSR is enabled with PERI_PDM_SPEAKER_DITHER_EN.
package peri_pdm_pkg;

  localparam logic AdrData = 1'b0;
  localparam logic AdrCtrl = 1'b1;

  localparam int CtrlEnBit     = 0;
  localparam int CtrlClrUdrBit = 2;
  localparam int CtrlClrOvfBit = 3;

  localparam int StEnBit    = 0;
  localparam int StEmptyBit = 1;
  localparam int StUdrBit   = 2;
  localparam int StOvfBit   = 3;
  localparam int StFullBit  = 4;
  localparam int StLvlLsb   = 5;

  localparam logic [15:0] LfsrSeed = 16'hACE1;
  localparam logic [15:0] LfsrTaps = 16'hB400;

  typedef struct packed {
    logic [2:0] level;
    logic       full;
    logic       ovf;
    logic       udr;
    logic       empty;
    logic       en;
  } status_t;

  function automatic logic [2:0] sat_level(
    input logic [31:0] lvl
  );
    return (lvl > 32'd7) ? 3'd7 : lvl[2:0];
  endfunction

endpackage

// File: rtl/peri_pdm_fifo.sv
// Synchronous first-word-fall-through FIFO holding PCM samples.
// A push to a full FIFO is accepted when a pop happens in the same cycle.
module peri_pdm_fifo #(
  parameter int Depth = 4,
  parameter int Width = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push,
  input  logic                       pop,
  input  logic [Width-1:0]           din,
  output logic [Width-1:0]           dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(Depth):0]     level
);

  localparam int AW = $clog2(Depth);
  localparam logic [AW:0] CntOne = (AW+1)'(1);
  localparam logic [AW:0] CntMax = (AW+1)'(Depth);
  localparam logic [AW-1:0] PtrOne = AW'(1);

  logic [Width-1:0] mem [Depth];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CntMax);
  assign level   = cnt;
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PtrOne;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PtrOne;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CntOne;
        2'b01:   cnt <= cnt - CntOne;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/peri_pdm_speaker.sv
// Wishbone PDM speaker: FIFO-fed first-order sigma-delta modulator.
// Define PERI_PDM_SPEAKER_DITHER_EN to add LFSR carry-in dither.
module peri_pdm_speaker
  import peri_pdm_pkg::*;
#(
  parameter int ClkHz     = 48_000_000,
  parameter int PdmHz     = 3_000_000,
  parameter int Osr       = 8,
  parameter int FifoDepth = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       wb_we_i,
  input  logic       wb_adr_i,
  input  logic [7:0] wb_dat_i,
  input  logic       wb_stb_i,
  output logic [7:0] wb_dat_o,
  output logic       wb_ack_o,
  output logic       pdm_clk_o,
  output logic       pdm_data_o,
  output logic       irq_o
);

  localparam int HalfTicks = ClkHz / PdmHz / 2;
  localparam int DivW = (HalfTicks > 1) ? $clog2(HalfTicks) : 1;
  localparam logic [DivW-1:0] DivLoad = DivW'(HalfTicks - 1);
  localparam int CntW = $clog2(Osr);
  localparam logic [CntW-1:0] CntLast = CntW'(Osr - 1);
  localparam int LvlW = $clog2(FifoDepth) + 1;
  localparam logic [LvlW-1:0] LvlLow = LvlW'(FifoDepth / 2);

  logic            en_q;
  logic [DivW-1:0] div_q;
  logic            pclk_q;
  logic            pdat_q;
  logic [7:0]      acc_q;
  logic [CntW-1:0] bit_cnt_q;
  logic [7:0]      sample_q;
  logic            udr_q;
  logic            ovf_q;
  logic            irq_q;
  logic            ack_q;
  logic [7:0]      rdata_q;

  logic            fire;
  logic            wr_data;
  logic            wr_ctrl;
  logic            rd;
  logic            tick;
  logic            fall_evt;
  logic            last_bit;
  logic            cin;
  logic [8:0]      sum;
  logic            fifo_pop;
  logic            starve;
  logic [7:0]      fifo_dout;
  logic            fifo_empty;
  logic            fifo_full;
  logic [LvlW-1:0] fifo_level;
  status_t         st;
  logic [7:0]      rd_mux;
  logic            unused_dat;

  assign unused_dat = ^{wb_dat_i[7:4], wb_dat_i[1]};

  assign fire    = wb_stb_i & ~ack_q;
  assign wr_data = fire & wb_we_i & (wb_adr_i == AdrData);
  assign wr_ctrl = fire & wb_we_i & (wb_adr_i == AdrCtrl);
  assign rd      = fire & ~wb_we_i;

  assign tick     = en_q & (div_q == '0);
  assign fall_evt = tick & pclk_q;
  assign last_bit = (bit_cnt_q == CntLast);
  assign fifo_pop = fall_evt & last_bit & ~fifo_empty;
  assign starve   = fall_evt & last_bit & fifo_empty;

`ifdef PERI_PDM_SPEAKER_DITHER_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= LfsrSeed;
    end else if (fall_evt) begin
      lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrTaps : 16'h0);
    end
  end

  assign cin = lfsr_q[0];
`else
  assign cin = 1'b0;
`endif

  assign sum = {1'b0, acc_q} + {1'b0, sample_q} + {8'd0, cin};

  peri_pdm_fifo #(
    .Depth (FifoDepth),
    .Width (8)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (wr_data),
    .pop    (fifo_pop),
    .din    (wb_dat_i),
    .dout   (fifo_dout),
    .empty  (fifo_empty),
    .full   (fifo_full),
    .level  (fifo_level)
  );

  // Modulator is held idle and cleared whenever disabled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q     <= DivLoad;
      pclk_q    <= 1'b0;
      pdat_q    <= 1'b0;
      acc_q     <= '0;
      bit_cnt_q <= '0;
    end else if (!en_q) begin
      div_q     <= DivLoad;
      pclk_q    <= 1'b0;
      pdat_q    <= 1'b0;
      acc_q     <= '0;
      bit_cnt_q <= '0;
    end else if (tick) begin
      div_q  <= DivLoad;
      pclk_q <= ~pclk_q;
      if (pclk_q) begin
        pdat_q    <= sum[8];
        acc_q     <= sum[7:0];
        bit_cnt_q <= bit_cnt_q + CntW'(1);
      end
    end else begin
      div_q <= div_q - DivW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sample_q <= 8'h80;
    end else if (fifo_pop) begin
      sample_q <= fifo_dout;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q <= 1'b0;
    end else if (wr_ctrl) begin
      en_q <= wb_dat_i[CtrlEnBit];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      udr_q <= 1'b0;
    end else if (starve) begin
      udr_q <= 1'b1;
    end else if (wr_ctrl && wb_dat_i[CtrlClrUdrBit]) begin
      udr_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q <= 1'b0;
    end else if (wr_data && fifo_full && !fifo_pop) begin
      ovf_q <= 1'b1;
    end else if (wr_ctrl && wb_dat_i[CtrlClrOvfBit]) begin
      ovf_q <= 1'b0;
    end
  end

  always_comb begin
    st       = '0;
    st.en    = en_q;
    st.empty = fifo_empty;
    st.udr   = udr_q;
    st.ovf   = ovf_q;
    st.full  = fifo_full;
    st.level = sat_level(32'(fifo_level));
  end

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      (wb_adr_i == AdrData): rd_mux = sample_q;
      (wb_adr_i == AdrCtrl): rd_mux = st;
      default:               rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      ack_q   <= fire;
      rdata_q <= rd ? rd_mux : 8'h00;
      irq_q   <= en_q & (fifo_level <= LvlLow);
    end
  end

  assign wb_ack_o   = ack_q;
  assign wb_dat_o   = rdata_q;
  assign pdm_clk_o  = pclk_q;
  assign pdm_data_o = pdat_q;
  assign irq_o      = irq_q;

endmodule
